// File: rtl/irq_btn_pkg.sv
// irq_btn_pkg: edge-mode encodings and the event-qualification helper shared by the IRQ button front end.
package irq_btn_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE  = 2'd0,
        EDGE_FALL  = 2'd1,
        EDGE_BOTH  = 2'd2,
        EDGE_LEVEL = 2'd3
    } edge_mode_e;

    function automatic logic edge_hit(logic [1:0] mode, logic rise, logic fall);
        return mode == EDGE_RISE ? rise :
               mode == EDGE_FALL ? fall :
               mode == EDGE_BOTH ? (rise | fall) : 1'b0;
    endfunction

endpackage

// File: rtl/irq_btn_frontend_debounce_ch.sv
// debounce_ch: one button channel -- synchroniser, stability counter, debounced level and edge event.
module debounce_ch
    import irq_btn_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 100000,
    parameter int         SYNC_STAGES     = 2,
    parameter logic [1:0] MODE            = EDGE_RISE
) (
    input  logic clk_i,
    input  logic srst_n_i,
    input  logic btn_i,
    output logic state_o,
    output logic event_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   differs;
    logic                   toggle;

    assign differs = sync_q[SYNC_STAGES-1] != state_o;
    assign toggle  = differs && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
    assign event_o = edge_hit(MODE, toggle & ~state_o, toggle & state_o);

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            state_o <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_i};
            cnt_q   <= (!differs || toggle) ? '0 : cnt_q + 1'b1;
            state_o <= state_o ^ toggle;
        end
    end

endmodule

// File: rtl/irq_btn_frontend.sv
// irq_btn_frontend: debounced button inputs with per-channel edge/level interrupt pending flags,
// acknowledge and mask onto a single interrupt line.
module irq_btn_frontend
    import irq_btn_pkg::*;
#(
    parameter int                  N_CH            = 4,
    parameter int                  DEBOUNCE_CYCLES = 100000,
    parameter int                  SYNC_STAGES     = 2,
    parameter logic [2*N_CH-1:0]   EDGE_MODE       = '0
) (
    input  logic            clk_i,
    input  logic            srst_n_i,
    input  logic [N_CH-1:0] btn_i,
    input  logic [N_CH-1:0] irq_mask_i,
    input  logic [N_CH-1:0] irq_ack_i,
    output logic [N_CH-1:0] btn_state_o,
    output logic [N_CH-1:0] irq_pending_o,
    output logic            irq_o
);
    logic [N_CH-1:0] ev;
    logic [N_CH-1:0] pend_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES),
            .MODE           (EDGE_MODE[2*i+:2])
        ) u_ch (
            .clk_i   (clk_i),
            .srst_n_i(srst_n_i),
            .btn_i   (btn_i[i]),
            .state_o (btn_state_o[i]),
            .event_o (ev[i])
        );
        // level channels mirror the debounced state and never latch
        assign irq_pending_o[i] = (EDGE_MODE[2*i+:2] == EDGE_LEVEL) ? btn_state_o[i] : pend_q[i];
    end

    // a new event wins over a simultaneous acknowledge
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) pend_q <= '0;
        else           pend_q <= ev | (pend_q & ~irq_ack_i);
    end

    assign irq_o = |(irq_pending_o & irq_mask_i);

endmodule

// File: tb/tb_irq_btn_frontend.sv
// tb_irq_btn_frontend: directed scenarios plus randomized traffic checked against a sample-window reference model.
module tb_irq_btn_frontend;
    localparam int         N    = 4;
    localparam int         DC   = 4;
    localparam int         SYNC = 2;
    localparam logic [7:0] EM   = 8'b11_10_01_00;

    logic         clk = 1'b0;
    logic         srst_n = 1'b0;
    logic [N-1:0] btn = '0;
    logic [N-1:0] mask = 4'b0001;
    logic [N-1:0] ack = '0;
    logic [N-1:0] btn_state;
    logic [N-1:0] pend;
    logic         irq;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total = 0;

    logic [N-1:0] hist[$];
    logic [N-1:0] m_state = '0;
    logic [N-1:0] m_pend = '0;

    always #5 clk = ~clk;

    irq_btn_frontend #(
        .N_CH(N), .DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SYNC), .EDGE_MODE(EM)
    ) dut (
        .clk_i(clk), .srst_n_i(srst_n), .btn_i(btn), .irq_mask_i(mask), .irq_ack_i(ack),
        .btn_state_o(btn_state), .irq_pending_o(pend), .irq_o(irq)
    );

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // The debounced level flips when the last DC synchronised samples (each SYNC edges old) all differ from it.
    task automatic tick();
        logic [N-1:0] prev;
        logic [1:0]   md;
        int           t;
        bit           flip, ev;
        @(posedge clk);
        if (!srst_n) begin
            hist.push_back('0);
            for (int k = 0; k < SYNC; k++) hist[hist.size()-1-k] = '0;
            m_state = '0;
            m_pend  = '0;
        end else begin
            hist.push_back(btn);
            t = hist.size() - 1;
            prev = m_state;
            for (int c = 0; c < N; c++) begin
                flip = 1'b1;
                for (int k = 0; k < DC; k++)
                    if (hist[t-SYNC-k][c] == prev[c]) flip = 1'b0;
                m_state[c] = prev[c] ^ flip;
                md = EM[2*c+:2];
                ev = flip && (md == 2'd0 ? !prev[c] : md == 2'd1 ? prev[c] : md == 2'd2);
                m_pend[c] = (md == 2'd3) ? m_state[c] : (ev || (m_pend[c] && !ack[c]));
            end
        end
        #1;
        check("model_state", 32'(btn_state), 32'(m_state));
        check("model_pend", 32'(pend), 32'(m_pend));
        check("model_irq", 32'(irq), 32'(|(m_pend & mask)));
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) hist.push_back('0);
        // reset state
        ticks(2);
        check("reset_state", 32'(btn_state), 0);
        check("reset_pend", 32'(pend), 0);
        check("reset_irq", 32'(irq), 0);
        srst_n = 1'b1;
        ticks(3);
        // ch0 rising: six edges from first sample to new level
        btn[0] = 1'b1;
        ticks(5);
        check("ch0_rise_early", 32'(btn_state[0]), 0);
        tick();
        check("ch0_rise_state", 32'(btn_state), 32'h1);
        check("ch0_rise_pend", 32'(pend), 32'h1);
        check("ch0_rise_irq", 32'(irq), 1);
        ack = 4'b0001; tick(); ack = '0;
        check("ch0_ack", 32'(pend[0]), 0);
        btn[0] = 1'b0;
        ticks(8);
        // short glitch is discarded
        btn[0] = 1'b1; ticks(3); btn[0] = 1'b0;
        ticks(20);
        check("glitch_state", 32'(btn_state[0]), 0);
        check("glitch_pend", 32'(pend[0]), 0);
        // ch1 falling mode
        btn[1] = 1'b1; ticks(8);
        check("ch1_press_state", 32'(btn_state[1]), 1);
        check("ch1_press_pend", 32'(pend[1]), 0);
        btn[1] = 1'b0; ticks(8);
        check("ch1_release_pend", 32'(pend[1]), 1);
        // ch2 both edges
        btn[2] = 1'b1; ticks(8);
        check("ch2_press_pend", 32'(pend[2]), 1);
        ack = 4'b0100; tick(); ack = '0;
        check("ch2_ack", 32'(pend[2]), 0);
        btn[2] = 1'b0; ticks(8);
        check("ch2_release_pend", 32'(pend[2]), 1);
        // ack coinciding with a new event loses
        btn[0] = 1'b1; ticks(5);
        ack = 4'b0001; tick();
        check("ack_vs_event", 32'(pend[0]), 1);
        tick(); ack = '0;
        check("ack_next", 32'(pend[0]), 0);
        // ch3 level mode ignores ack
        btn[3] = 1'b1; ticks(6);
        check("ch3_level_high", 32'(pend[3]), 1);
        ack = 4'b1000; tick(); ack = '0;
        check("ch3_ack_ignored", 32'(pend[3]), 1);
        btn[3] = 1'b0; ticks(5);
        check("ch3_release_early", 32'(pend[3]), 1);
        tick();
        check("ch3_release", 32'(pend[3]), 0);
        // reset mid-debounce
        btn = '0; ticks(8);
        ack = 4'b1111; tick(); ack = '0;
        btn[0] = 1'b1; ticks(3);
        srst_n = 1'b0; tick();
        check("midrst_state", 32'(btn_state), 0);
        check("midrst_pend", 32'(pend), 0);
        check("midrst_irq", 32'(irq), 0);
        srst_n = 1'b1; ticks(5);
        check("post_rst_early", 32'(pend[0]), 0);
        tick();
        check("post_rst_pend", 32'(pend[0]), 1);
        // randomized traffic
        for (int r = 0; r < 150; r++) begin
            btn  = N'($urandom);
            mask = N'($urandom);
            for (int h = $urandom_range(1, 8); h > 0; h--) begin
                ack = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
                srst_n = ($urandom_range(0, 200) != 0);
                tick();
            end
        end
        srst_n = 1'b1; ack = '0;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/irq_btn_frontend.md
IRQ_BTN_FRONTEND -- requirements
Module: irq_btn_frontend

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of button/IRQ channels, 1..32.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 100000: consecutive stable cycles required to accept a new level, >=1.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth, >=2.
REQ-004 SHALL have parameter EDGE_MODE, width 2*N_CH, default all 0: per channel field [2i+1:2i]; 0=rising, 1=falling, 2=both, 3=level.
REQ-005 SHALL have port clk_i, input, 1: the single clock; all logic on rising edge.
REQ-006 SHALL have port srst_n_i, input, 1: synchronous reset, active-low.
REQ-007 SHALL have port btn_i, input, N_CH: raw asynchronous button inputs.
REQ-008 SHALL have port irq_mask_i, input, N_CH: 1 enables the channel onto irq_o.
REQ-009 SHALL have port irq_ack_i, input, N_CH: one-cycle clear pulse per channel.
REQ-010 SHALL have port btn_state_o, output, N_CH: debounced level.
REQ-011 SHALL have port irq_pending_o, output, N_CH: latched pending flags.
REQ-012 SHALL have port irq_o, output, 1: OR of (irq_pending_o & irq_mask_i), combinational.

Function
REQ-013 SHALL pass each btn_i bit through SYNC_STAGES flops before any other use.
REQ-014 SHALL keep a per-channel counter of width $clog2(DEBOUNCE_CYCLES+1); counter clears on any cycle where synchronised input equals btn_state_o.
REQ-015 SHALL increment the counter while synchronised input differs from btn_state_o; on the edge where counter == DEBOUNCE_CYCLES-1 and input still differs, btn_state_o toggles and counter clears.
REQ-016 SHALL give latency SYNC_STAGES + DEBOUNCE_CYCLES clock edges from the first edge sampling a new stable btn_i level to btn_state_o change.
REQ-017 SHALL discard any glitch shorter than DEBOUNCE_CYCLES synchronised cycles, with no btn_state_o or pending change.
REQ-018 SHALL generate a per-channel event on the same edge btn_state_o changes: mode 0 on 0->1, mode 1 on 1->0, mode 2 on either.
REQ-019 SHALL set irq_pending_o on an event regardless of irq_mask_i; masking only gates irq_o.
REQ-020 SHALL clear irq_pending_o on irq_ack_i; event and ack on the same edge leave pending set (set wins).
REQ-021 SHALL, for mode 3, drive irq_pending_o equal to btn_state_o and ignore irq_ack_i.
REQ-022 SHALL treat channels fully independently; simultaneous events on several channels all latch.
REQ-023 SHALL not count repeated events: pending already set stays set, no overflow state.

Reset
REQ-024 SHALL on srst_n_i low at a clock edge clear synchroniser flops, counters, btn_state_o and irq_pending_o to 0; irq_o therefore 0.
REQ-025 SHALL abort any debounce in progress on reset; a button held high through reset release debounces to 1 afterwards and raises a rising/both event.
REQ-026 SHALL ignore irq_ack_i and btn_i while srst_n_i is low.

Structure
REQ-027 SHALL place EDGE_MODE encodings (EDGE_RISE=0, EDGE_FALL=1, EDGE_BOTH=2, EDGE_LEVEL=3) in shared package irq_btn_pkg.
REQ-028 SHALL implement one channel (synchroniser, counter, stable level, event) as sub-module debounce_ch, instantiated N_CH times by generate; pending/mask logic stays in the top.

Verification (N_CH=4, DEBOUNCE_CYCLES=4, SYNC_STAGES=2, EDGE_MODE=8'b11_10_01_00)
REQ-029 SHALL cover: btn_i[0] 0->1 held -> btn_state_o[0]=1 and irq_pending_o[0]=1 exactly 6 edges later; irq_o=1 with irq_mask_i=4'b0001.
REQ-030 SHALL cover: btn_i[0] high pulse of 3 synchronised cycles -> btn_state_o and irq_pending_o unchanged for 20 cycles.
REQ-031 SHALL cover: ch1 (falling) pressed then released -> pending[1] only after release; ch2 (both) -> pending on press, ack, pending again on release.
REQ-032 SHALL cover: irq_ack_i[0] on the same edge as a new ch0 event -> irq_pending_o[0] stays 1; ack next cycle -> 0.
REQ-033 SHALL cover: ch3 level mode held high -> irq_pending_o[3]=1, irq_ack_i[3] ignored; release -> 0 after 6 edges.
REQ-034 SHALL cover: srst_n_i low mid-debounce with btn_i[0]=1 -> all outputs 0 next edge; after release, pending[0]=1 6 edges later.
